// File: rtl/disp_conf_weighter.sv
// Disparity/confidence weighting: groups DEC_FACTOR mask columns into a block, scales confidence by valid-pixel fraction.
// Latency 3 edges from final beat to FIFO write; in_ready deasserts when the show-ahead output FIFO nears full.

module disp_conf_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 2048
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  input  logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH):0]     used
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   used_q;
  logic          pop;

  // Pop qualifies on stored occupancy only, never on the incoming write.
  assign rd_vld = (used_q != '0);
  assign pop    = rd_vld && rd_rdy;
  assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
  assign used   = used_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (wr_vld) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_vld, pop})
        2'b10:   used_q <= used_q + 1'b1;
        2'b01:   used_q <= used_q - 1'b1;
        default: used_q <= used_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld) mem_q[wr_ptr_q] <= wr_dat;
  end
endmodule

module disp_conf_weighter #(
  parameter int DISP_BITS  = 5,
  parameter int CONF_BITS  = 8,
  parameter int DEC_FACTOR = 2,
  parameter int GAIN       = 2,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_sof,
  input  logic [DEC_FACTOR-1:0]          pixels_in,
  input  logic [DISP_BITS-1:0]           disp_in,
  input  logic [CONF_BITS-1:0]           conf_in,
  input  logic                           mask_invert,
  input  logic [CONF_BITS-1:0]           conf_thresh,
  output logic [DISP_BITS+CONF_BITS-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready
);
  localparam int CNT_W  = $clog2(DEC_FACTOR*DEC_FACTOR + 1);
  localparam int GRP_W  = (DEC_FACTOR > 1) ? $clog2(DEC_FACTOR) : 1;
  localparam int RECIP  = 65536 / (DEC_FACTOR*DEC_FACTOR);
  localparam int PROD_W = CONF_BITS + CNT_W + 20;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [CONF_BITS-1:0] CONF_MAX = '1;

  typedef struct packed {
    logic [DISP_BITS-1:0] disp;
    logic [CONF_BITS-1:0] conf;
  } result_t;

  logic                  acc;
  logic [DEC_FACTOR-1:0] pix_sel;
  logic [CNT_W-1:0]      col_cnt, blk_sum;
  logic [GRP_W-1:0]      pos;
  logic                  is_final;
  logic [AW:0]           fifo_used;

  logic [GRP_W-1:0]      grp_cnt_q;
  logic [CNT_W-1:0]      acc_q;
  logic                  s1_vld_q;
  logic [CNT_W-1:0]      s1_cnt_q;
  logic [DISP_BITS-1:0]  s1_disp_q;
  logic [CONF_BITS-1:0]  s1_conf_q;
  logic                  s2_vld_q;
  logic [PROD_W-1:0]     s2_prod_q;
  logic [DISP_BITS-1:0]  s2_disp_q;
  logic                  s3_vld_q;
  result_t               s3_res_q;

  logic [PROD_W-1:0]     prod_d;
  logic [PROD_W-1:0]     shifted;
  logic [CONF_BITS-1:0]  w_sat;
  result_t               res_d;

  assign in_ready = (fifo_used <= (AW+1)'(FIFO_DEPTH - 4));
  assign acc      = in_valid && in_ready;

  always_comb begin
    pix_sel = pixels_in ^ {DEC_FACTOR{~mask_invert}};
    col_cnt = '0;
    for (int i = 0; i < DEC_FACTOR; i++) col_cnt = col_cnt + CNT_W'(pix_sel[i]);
  end

  // SOF forces position 0 so a partial block in progress is simply dropped.
  assign pos      = in_sof ? '0 : grp_cnt_q;
  assign is_final = (pos == GRP_W'(DEC_FACTOR - 1));
  assign blk_sum  = ((pos == '0) ? '0 : acc_q) + col_cnt;

  assign prod_d  = PROD_W'(s1_conf_q) * PROD_W'(s1_cnt_q) * PROD_W'(GAIN) * PROD_W'(RECIP);
  assign shifted = s2_prod_q >> 16;
  assign w_sat   = (shifted > PROD_W'(CONF_MAX)) ? CONF_MAX : shifted[CONF_BITS-1:0];

  always_comb begin
    res_d = '0;
    if (w_sat >= conf_thresh) begin
      res_d.disp = s2_disp_q;
      res_d.conf = w_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grp_cnt_q <= '0;
      acc_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_cnt_q  <= '0;
      s1_disp_q <= '0;
      s1_conf_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_prod_q <= '0;
      s2_disp_q <= '0;
      s3_vld_q  <= 1'b0;
      s3_res_q  <= '0;
    end else begin
      s1_vld_q <= acc && is_final;
      if (acc) begin
        acc_q     <= blk_sum;
        grp_cnt_q <= is_final ? '0 : pos + 1'b1;
        if (is_final) begin
          s1_cnt_q  <= blk_sum;
          s1_disp_q <= disp_in;
          s1_conf_q <= conf_in;
        end
      end
      s2_vld_q  <= s1_vld_q;
      s2_prod_q <= prod_d;
      s2_disp_q <= s1_disp_q;
      s3_vld_q  <= s2_vld_q;
      s3_res_q  <= res_d;
    end
  end

  disp_conf_fifo #(
    .W     (DISP_BITS + CONF_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (s3_vld_q),
    .wr_dat (s3_res_q),
    .rd_rdy (out_ready),
    .rd_vld (out_valid),
    .rd_dat (out_data),
    .used   (fifo_used)
  );
endmodule

// File: tb/tb_disp_conf_weighter.sv
// Directed scoreboard bench for disp_conf_weighter: DEC_FACTOR=2, GAIN=2, 16-entry FIFO.
module tb_disp_conf_weighter;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sof = 1'b0;
  logic [1:0]  pixels_in = '0;
  logic [4:0]  disp_in = '0;
  logic [7:0]  conf_in = '0;
  logic        mask_invert = 1'b0;
  logic [7:0]  conf_thresh = '0;
  logic [12:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_exp;

  disp_conf_weighter #(
    .DISP_BITS(5), .CONF_BITS(8), .DEC_FACTOR(2), .GAIN(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .pixels_in(pixels_in), .disp_in(disp_in), .conf_in(conf_in), .mask_invert(mask_invert),
    .conf_thresh(conf_thresh), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next posedge whenever valid && ready here.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no output", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", out_data, mon_exp);
        pops++;
      end
    end
  end

  task automatic beat(input logic [1:0] p, input logic sof, input logic [4:0] d, input logic [7:0] c);
    int n = 0;
    in_valid = 1'b1; pixels_in = p; in_sof = sof; disp_in = d; conf_in = c;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic blk(input logic [1:0] p0, input logic [1:0] p1, input logic sof,
                     input logic [4:0] d, input logic [7:0] c,
                     input logic [4:0] ed, input logic [7:0] ec);
    beat(p0, sof, 5'd0, 8'd0);
    beat(p1, 1'b0, d, c);
    exp_q.push_back({ed, ec});
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    int b;
    int pops0;
    bit got;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk); #1;

    // Full block: count 4, 100*4*2/4 = 200; latency check with output held.
    blk(2'b00, 2'b00, 1'b1, 5'd7, 8'd100, 5'd7, 8'd200);
    @(negedge clk); check("lat_n1", out_valid, 0);
    @(negedge clk); check("lat_n2", out_valid, 0);
    @(negedge clk); check("lat_n3", out_valid, 0);
    @(negedge clk); check("lat_n4", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    blk(2'b01, 2'b00, 1'b0, 5'd9,  8'd100, 5'd9,  8'd150);
    blk(2'b00, 2'b00, 1'b0, 5'd10, 8'd200, 5'd10, 8'd255);
    blk(2'b11, 2'b11, 1'b0, 5'd11, 8'd200, 5'd11, 8'd0);
    settle();
    conf_thresh = 8'd160;
    blk(2'b01, 2'b00, 1'b0, 5'd12, 8'd100, 5'd0,  8'd0);
    blk(2'b00, 2'b00, 1'b0, 5'd13, 8'd100, 5'd13, 8'd200);
    settle();
    conf_thresh = 8'd0;
    mask_invert = 1'b1;
    blk(2'b11, 2'b11, 1'b0, 5'd14, 8'd50, 5'd14, 8'd100);
    settle();
    mask_invert = 1'b0;

    // SOF resync: the lone first beat must not contribute.
    beat(2'b00, 1'b0, 5'd1, 8'd1);
    beat(2'b11, 1'b1, 5'd0, 8'd0);
    beat(2'b01, 1'b0, 5'd15, 8'd100);
    exp_q.push_back({5'd15, 8'd50});
    drain(1'b0);

    // Backpressure: 16 entries, stall threshold 12 -> 29 beats accepted, 14 blocks.
    out_ready = 1'b0;
    nacc = 0;
    pops0 = pops;
    in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      b = nacc / 2;
      pixels_in = 2'b00; in_sof = 1'b0;
      disp_in = 5'(b); conf_in = 8'(b + 1);
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      if (got) begin
        nacc++;
        if (nacc % 2 == 0) exp_q.push_back({5'(b), 8'(2 * (b + 1))});
      end
    end
    in_valid = 1'b0;
    check("bp_beats_accepted", nacc, 29);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    drain(1'b1);
    check("bp_pop_count", pops - pops0, 14);
    check("bp_in_ready_back", in_ready, 1);

    // Reset with 5 results in the FIFO and 2 in flight.
    out_ready = 1'b0;
    for (int j = 0; j < 7; j++)
      blk(2'b00, 2'b00, (j == 0), 5'(j), 8'd20, 5'(j), 8'd40);
    check("pre_reset_vld", out_valid, 1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_data", out_data, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    blk(2'b01, 2'b00, 1'b0, 5'd21, 8'd100, 5'd21, 8'd150);
    drain(1'b0);

    // Reset with a partial block pending: next block starts from position 0.
    beat(2'b00, 1'b0, 5'd0, 8'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    blk(2'b01, 2'b11, 1'b0, 5'd22, 8'd100, 5'd22, 8'd50);
    drain(1'b0);

    repeat (10) @(posedge clk);
    #1;
    check("final_empty", out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
